// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared definitions for the LCD display path. It holds the panel geometry,
// the RGB565 colour constants, the frame sequencer state encoding and the
// frame mode (read from the pixel source, or fill with a constant colour).
package lcd_pkg;

  localparam int LCD_WIDTH  = 240;
  localparam int LCD_HEIGHT = 320;

  localparam logic [15:0] COLOR_BLACK = 16'h0000;
  localparam logic [15:0] COLOR_WHITE = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_FETCH     = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_PRINT     = 3'd4,
    ST_GAP       = 3'd5,
    ST_DONE      = 3'd6
  } seq_state_t;

  typedef enum logic {
    MODE_READ = 1'b0,
    MODE_FILL = 1'b1
  } seq_mode_t;

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// lcd_frame_sequencer_if
// Groups the pixel-source read port and the lt24_lcd_driver connection.
//   rd_en / rd_x / rd_y : read strobe and coordinate toward the pixel source
//   rd_rgb              : source data, valid the cycle after rd_en
//   lcd_pixel_rgb       : colour presented to the driver
//   lcd_print           : one-cycle print pulse to the driver
//   lcd_initialized     : driver ready flag
// The master modport is the sequencer side. The slave modport is the
// source/driver side.
interface lcd_frame_sequencer_if #(
  parameter int X_W = 8,
  parameter int Y_W = 9
);

  logic           rd_en;
  logic [X_W-1:0] rd_x;
  logic [Y_W-1:0] rd_y;
  logic [15:0]    rd_rgb;
  logic [15:0]    lcd_pixel_rgb;
  logic           lcd_print;
  logic           lcd_initialized;

  modport master (
    output rd_en, rd_x, rd_y, lcd_pixel_rgb, lcd_print,
    input  rd_rgb, lcd_initialized
  );

  modport slave (
    input  rd_en, rd_x, rd_y, lcd_pixel_rgb, lcd_print,
    output rd_rgb, lcd_initialized
  );

endinterface

// File: rtl/lcd_raster_counter.sv
// lcd_raster_counter
// Walks (x,y) through a frame in raster order. x runs fastest.
//   clk, reset (async, active-low), en (clock enable)
//   clear      : return to (0,0). This has priority over advance.
//   advance    : step to the next pixel. Advancing from the last pixel
//                returns to (0,0), so the coordinates never pass HEIGHT-1.
//   x, y       : current coordinate
//   last_pixel : high while at (WIDTH-1, HEIGHT-1)
module lcd_raster_counter
  import lcd_pkg::*;
#(
  parameter int WIDTH  = LCD_WIDTH,
  parameter int HEIGHT = LCD_HEIGHT,
  parameter int X_W    = $clog2(WIDTH),
  parameter int Y_W    = $clog2(HEIGHT)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last_pixel
);

  logic line_end;

  assign line_end   = (x == X_W'(WIDTH - 1));
  assign last_pixel = line_end && (y == Y_W'(HEIGHT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (clear || (advance && last_pixel)) begin
        x <= '0;
        y <= '0;
      end else if (advance) begin
        if (line_end) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
// Streams a full frame into the address-less lt24_lcd_driver. Each print
// writes the next pixel in raster order. Pixel colour comes from the pixel
// source (READ mode, 1-cycle read latency) or from a latched fill colour
// (FILL mode).
//   clk, reset (async, active-low), en (clock enable, freezes everything)
//   refresh_req : start a READ frame. fill_req : start a FILL frame with fill_rgb.
//   busy        : frame in progress. frame_done : pulse after the last gap.
//   bus         : pixel-source read port and driver connection (master side)
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int WIDTH     = LCD_WIDTH,
  parameter int HEIGHT    = LCD_HEIGHT,
  parameter int PRINT_GAP = 4,
  parameter int X_W       = $clog2(WIDTH),
  parameter int Y_W       = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 refresh_req,
  input  logic                 fill_req,
  input  logic [15:0]          fill_rgb,
  output logic                 busy,
  output logic                 frame_done,
  lcd_frame_sequencer_if.master bus
);

  localparam int GAP_W = $clog2(PRINT_GAP + 1);

  seq_state_t     state;
  seq_mode_t      mode;
  logic [GAP_W-1:0] gap_cnt;
  logic           rd_en_q;
  logic           print_q;
  logic           done_q;
  logic           busy_q;
  logic [15:0]    pixel_q;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic           last_pixel;

  logic           abort;
  logic           accept;
  logic           gap_end;
  logic           cnt_clear;
  logic           cnt_advance;

  // Losing the driver in any active state sends us back to WAIT_INIT.
  // The raster counter clears on acceptance, on abort, and when the
  // frame completes, so every frame starts from (0,0).
  always_comb begin
    abort       = 1'b0;
    accept      = 1'b0;
    gap_end     = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;
    abort       = (state != ST_WAIT_INIT) && !bus.lcd_initialized;
    accept      = (state == ST_IDLE) && !abort && (fill_req || refresh_req);
    gap_end     = (state == ST_GAP) && !abort && (gap_cnt == GAP_W'(1));
    cnt_clear   = abort || accept || (gap_end && last_pixel);
    cnt_advance = gap_end && !last_pixel;
  end

  lcd_raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .x          (x),
    .y          (y),
    .last_pixel (last_pixel)
  );

  // The pulse registers (rd_en_q, print_q, done_q) are set when the FSM
  // enters FETCH, PRINT or DONE. Each one then matches its state for
  // exactly one enabled cycle. If en is low they hold, so the pulse is
  // reissued once en returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_WAIT_INIT;
      mode    <= MODE_READ;
      gap_cnt <= '0;
      rd_en_q <= 1'b0;
      print_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pixel_q <= COLOR_BLACK;
    end else if (en) begin
      rd_en_q <= 1'b0;
      print_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort) begin
        state   <= ST_WAIT_INIT;
        mode    <= MODE_READ;
        gap_cnt <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_INIT: begin
            if (bus.lcd_initialized) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (fill_req) begin
              mode    <= MODE_FILL;
              pixel_q <= fill_rgb;
              busy_q  <= 1'b1;
              print_q <= 1'b1;
              state   <= ST_PRINT;
            end else if (refresh_req) begin
              mode    <= MODE_READ;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              state   <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            state <= ST_CAPTURE;
          end
          ST_CAPTURE: begin
            pixel_q <= bus.rd_rgb;
            print_q <= 1'b1;
            state   <= ST_PRINT;
          end
          ST_PRINT: begin
            gap_cnt <= GAP_W'(PRINT_GAP);
            state   <= ST_GAP;
          end
          ST_GAP: begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_end) begin
              if (last_pixel) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= ST_DONE;
              end else if (mode == MODE_FILL) begin
                print_q <= 1'b1;
                state   <= ST_PRINT;
              end else begin
                rd_en_q <= 1'b1;
                state   <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_WAIT_INIT;
          end
        endcase
      end
    end
  end

  // The print pulse is also masked by lcd_initialized. If the driver drops
  // out in the same cycle as a pending print, that print is never issued.
  assign bus.rd_en         = rd_en_q & en;
  assign bus.rd_x          = x;
  assign bus.rd_y          = y;
  assign bus.lcd_pixel_rgb = pixel_q;
  assign bus.lcd_print     = print_q & en & bus.lcd_initialized;
  assign busy              = busy_q;
  assign frame_done        = done_q & en;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb_lcd_frame_sequencer
// Randomized self-checking bench for lcd_frame_sequencer on a small 4x3
// frame. The reference model works out each frame's expected print list,
// fetch coordinates and print spacing from the pixel index n:
// x = n % WIDTH, y = n / WIDTH.
module tb_lcd_frame_sequencer;
  import lcd_pkg::*;

  localparam int WIDTH     = 4;
  localparam int HEIGHT    = 3;
  localparam int PRINT_GAP = 4;
  localparam int X_W       = $clog2(WIDTH);
  localparam int Y_W       = $clog2(HEIGHT);
  localparam int TOTAL     = WIDTH * HEIGHT;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        refresh_req;
  logic        fill_req;
  logic [15:0] fill_rgb;
  logic        busy;
  logic        frame_done;
  logic [15:0] salt;

  int assertCount = 0;
  int failCount   = 0;

  // Observations recorded by the monitor
  int          cycleCount = 0;
  logic [15:0] printRgb[$];
  int          printCycle[$];
  int          fetchX[$];
  int          fetchY[$];
  int          doneCount = 0;

  lcd_frame_sequencer_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  lcd_frame_sequencer #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .PRINT_GAP (PRINT_GAP),
    .X_W       (X_W),
    .Y_W       (Y_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .refresh_req (refresh_req),
    .fill_req    (fill_req),
    .fill_rgb    (fill_rgb),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Pixel source with one cycle of read latency. Its data is {y,x} xor a
  // per-frame salt.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_rgb <= {8'(bus.rd_y), 8'(bus.rd_x)} ^ salt;
  end

  // Records each print, fetch and frame_done seen on the falling edge
  always @(negedge clk) begin
    cycleCount++;
    if (bus.lcd_print) begin
      printRgb.push_back(bus.lcd_pixel_rgb);
      printCycle.push_back(cycleCount);
    end
    if (bus.rd_en) begin
      fetchX.push_back(int'(bus.rd_x));
      fetchY.push_back(int'(bus.rd_y));
    end
    if (frame_done) doneCount++;
  end

  function automatic logic [15:0] pixelData(input int n);
    return {8'(n / WIDTH), 8'(n % WIDTH)} ^ salt;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic doFill, input logic doRefresh, input logic [15:0] rgb);
    fill_req    = doFill;
    refresh_req = doRefresh;
    fill_rgb    = rgb;
    tick(1);
    fill_req    = 1'b0;
    refresh_req = 1'b0;
  endtask

  task automatic clearMon();
    printRgb.delete();
    printCycle.delete();
    fetchX.delete();
    fetchY.delete();
    doneCount = 0;
  endtask

  task automatic waitPrints(input int n, input int budget);
    for (int i = 0; i < budget && printRgb.size() < n; i++) tick(1);
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && doneCount == 0; i++) tick(1);
    tick(3);
  endtask

  task automatic checkFrame(input bit fillMode, input logic [15:0] color, input int stall);
    int period;
    period = fillMode ? 1 + PRINT_GAP : 3 + PRINT_GAP;
    checkOutput("printCount", printRgb.size(), TOTAL);
    for (int n = 0; n < printRgb.size() && n < TOTAL; n++)
      checkOutput(fillMode ? "fillRgb" : "readRgb", printRgb[n], fillMode ? color : pixelData(n));
    if (printRgb.size() == TOTAL) begin
      if (stall == 0) begin
        for (int n = 1; n < TOTAL; n++)
          checkOutput("printSpacing", printCycle[n] - printCycle[n-1], period);
      end else begin
        checkOutput("frameSpan", printCycle[TOTAL-1] - printCycle[0], (TOTAL - 1) * period + stall);
      end
    end
    if (fillMode) begin
      checkOutput("fillNoFetch", fetchX.size(), 0);
    end else begin
      checkOutput("fetchCount", fetchX.size(), TOTAL);
      for (int n = 0; n < fetchX.size() && n < TOTAL; n++)
        checkOutput("fetchCoord", fetchY[n] * 256 + fetchX[n], (n / WIDTH) * 256 + (n % WIDTH));
    end
    checkOutput("frameDoneCount", doneCount, 1);
    checkOutput("busyAfterFrame", busy, 0);
  endtask

  task automatic runFrame(input bit fillMode, input logic [15:0] color);
    clearMon();
    salt = 16'($urandom);
    if (fillMode) applyStimulus(1'b1, 1'b0, color);
    else          applyStimulus(1'b0, 1'b1, color);
    waitDone(400);
    checkFrame(fillMode, color, 0);
  endtask

  initial begin
    logic [15:0] color;
    reset       = 1'b1;
    en          = 1'b1;
    fill_req    = 1'b0;
    refresh_req = 1'b0;
    fill_rgb    = 16'h0000;
    salt        = 16'h0000;
    bus.lcd_initialized = 1'b0;
    #3 reset = 1'b0;
    tick(3);
    checkOutput("resetOutputs", {busy, frame_done, bus.rd_en, bus.lcd_print, bus.lcd_pixel_rgb, bus.rd_x, bus.rd_y}, 0);
    reset = 1'b1;
    tick(2);

    // Requests are dropped until the driver reports initialized
    clearMon();
    applyStimulus(1'b1, 1'b0, 16'hF800);
    tick(10);
    checkOutput("initGatePrints", printRgb.size(), 0);
    checkOutput("initGateBusy", busy, 0);
    bus.lcd_initialized = 1'b1;
    tick(2);

    // Fill frame: busy rises straight after acceptance
    clearMon();
    applyStimulus(1'b1, 1'b0, 16'hF800);
    checkOutput("busyOnAccept", busy, 1);
    waitDone(400);
    checkFrame(1'b1, 16'hF800, 0);

    // Read frame
    runFrame(1'b0, 16'h0000);

    // Simultaneous requests pick FILL; a mid-frame refresh is ignored
    clearMon();
    color = 16'($urandom);
    applyStimulus(1'b1, 1'b1, color);
    waitPrints(3, 100);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    waitDone(400);
    checkFrame(1'b1, color, 0);

    // en held low for 10 cycles during GAP of a read frame
    clearMon();
    salt = 16'($urandom);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    waitPrints(3, 100);
    en = 1'b0;
    tick(10);
    checkOutput("stallNoPrint", printRgb.size(), 3);
    en = 1'b1;
    waitDone(400);
    checkFrame(1'b0, 16'h0000, 10);

    // Driver drops out after the 5th print
    clearMon();
    applyStimulus(1'b1, 1'b0, COLOR_WHITE);
    waitPrints(5, 100);
    bus.lcd_initialized = 1'b0;
    tick(20);
    checkOutput("abortPrints", printRgb.size(), 5);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortNoDone", doneCount, 0);
    bus.lcd_initialized = 1'b1;
    tick(10);
    checkOutput("abortNoRestart", printRgb.size(), 5);
    runFrame(1'b1, COLOR_WHITE);

    // Asynchronous reset in the middle of a read frame
    clearMon();
    salt = 16'($urandom) | 16'h0101;
    applyStimulus(1'b0, 1'b1, 16'h0000);
    waitPrints(3, 100);
    tick(2);
    #2 reset = 1'b0;
    #1;
    checkOutput("midResetOutputs", {busy, frame_done, bus.rd_en, bus.lcd_print, bus.lcd_pixel_rgb, bus.rd_x, bus.rd_y}, 0);
    tick(1);
    reset = 1'b1;
    tick(3);

    // Random frames after recovery
    for (int i = 0; i < 4; i++) begin
      color = 16'($urandom);
      runFrame(1'($urandom_range(0, 1)), color);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
